// File: rtl/nes_ctrl_pkg.sv
// Shared NES joypad definitions: button bit positions and shift-register sizing,
// used by the controller model, the benches and the console's input logic.
package nes_ctrl_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned BTN_W = 8;
  localparam logic [3:0]  READ_MAX = 4'd8;

endpackage

// File: rtl/nes_controller_sim.sv
// NES joypad model: CD4021-style parallel-in/serial-out register with an optional
// time-scheduled button script for unattended benches.
module nes_controller_sim
  import nes_ctrl_pkg::*;
#(
  parameter bit          SCRIPT_EN = 1'b0,
  parameter logic [31:0] T1        = 32'd800000,
  parameter logic [31:0] T2        = 32'd2000000,
  parameter logic [31:0] T3        = 32'd2200000,
  parameter logic [7:0]  B0        = 8'h00,
  parameter logic [7:0]  B1        = 8'h08,
  parameter logic [7:0]  B2        = 8'h01,
  parameter logic [7:0]  B3        = 8'h80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic             rd,
  input  logic [BTN_W-1:0] btns,
  output logic             data,
  output logic [BTN_W-1:0] latched,
  output logic [3:0]       read_count
);

  logic [BTN_W-1:0] shift_r;
  logic [BTN_W-1:0] shift_nxt_s;
  logic [3:0]       read_count_r;
  logic [3:0]       read_count_nxt_s;
  logic             rd_q_r;
  logic             rd_fall_s;
  logic [31:0]      cycle_r;
  logic [BTN_W-1:0] btns_eff_s;

  function automatic logic [BTN_W-1:0] sched_btns(input logic [31:0] cyc);
    logic [BTN_W-1:0] b;
    if (cyc < T1) begin
      b = B0;
    end else if (cyc < T2) begin
      b = B1;
    end else if (cyc < T3) begin
      b = B2;
    end else begin
      b = B3;
    end
    return b;
  endfunction

  // Select live or scripted buttons
  always_comb begin
    btns_eff_s = btns;
    if (SCRIPT_EN) begin
      btns_eff_s = sched_btns(cycle_r);
    end else begin
      btns_eff_s = btns;
    end
  end

  assign rd_fall_s = rd_q_r & ~rd;

  // Next-state for the shift register; strobe dominates a coincident rd falling edge
  always_comb begin
    shift_nxt_s      = shift_r;
    read_count_nxt_s = read_count_r;
    if (strobe) begin
      shift_nxt_s      = btns_eff_s;
      read_count_nxt_s = 4'd0;
    end else if (rd_fall_s) begin
      shift_nxt_s = {1'b1, shift_r[BTN_W-1:1]};
      if (read_count_r < READ_MAX) begin
        read_count_nxt_s = read_count_r + 4'd1;
      end else begin
        read_count_nxt_s = READ_MAX;
      end
    end else begin
      shift_nxt_s      = shift_r;
      read_count_nxt_s = read_count_r;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_r      <= 8'h00;
      read_count_r <= 4'd0;
      rd_q_r       <= 1'b0;
      cycle_r      <= 32'd0;
    end else begin
      shift_r      <= shift_nxt_s;
      read_count_r <= read_count_nxt_s;
      rd_q_r       <= rd;
      if (cycle_r != 32'hFFFF_FFFF) begin
        cycle_r <= cycle_r + 32'd1;
      end else begin
        cycle_r <= cycle_r;
      end
    end
  end

  assign data       = shift_r[0];
  assign latched    = shift_r;
  assign read_count = read_count_r;

endmodule

// File: tb/tb_nes_controller_sim.sv
// Directed bench for nes_controller_sim: one live-button instance and one
// scripted instance with short schedule thresholds.
module tb_nes_controller_sim;
  import nes_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       strobe = 1'b0, rd = 1'b0;
  logic [7:0] btns = 8'h00;
  logic       data;
  logic [7:0] latched;
  logic [3:0] read_count;

  logic       s_strobe = 1'b0, s_rd = 1'b0;
  logic [7:0] s_btns = 8'hFF;
  logic       s_data;
  logic [7:0] s_latched;
  logic [3:0] s_read_count;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] bc = 32'd0;

  always #5 clk = ~clk;

  // Bench-side cycle count, cleared by the same reset as the DUT
  always @(posedge clk) begin
    if (!rst) bc <= 32'd0;
    else      bc <= bc + 32'd1;
  end

  nes_controller_sim u_live (
    .clk(clk), .rst(rst), .strobe(strobe), .rd(rd), .btns(btns),
    .data(data), .latched(latched), .read_count(read_count)
  );

  nes_controller_sim #(
    .SCRIPT_EN(1'b1), .T1(32'd10), .T2(32'd20), .T3(32'd30)
  ) u_script (
    .clk(clk), .rst(rst), .strobe(s_strobe), .rd(s_rd), .btns(s_btns),
    .data(s_data), .latched(s_latched), .read_count(s_read_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One read on the live port; checks the bit presented while rd is high
  task automatic rd_pulse(input string tag, input logic exp_bit);
    rd = 1'b1;
    tick();
    chk(tag, {31'd0, data}, {31'd0, exp_bit});
    rd = 1'b0;
    tick();
  endtask

  task automatic s_rd_pulse(input string tag, input logic exp_bit);
    s_rd = 1'b1;
    tick();
    chk(tag, {31'd0, s_data}, {31'd0, exp_bit});
    s_rd = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] pat;
    int guard;

    // Reset
    btns = 8'hA5;
    repeat (3) tick();
    chk("rst_data", {31'd0, data}, 32'd0);
    chk("rst_latched", {24'd0, latched}, 32'h00);
    chk("rst_count", {28'd0, read_count}, 32'd0);
    chk("rst_s_latched", {24'd0, s_latched}, 32'h00);
    rst = 1'b1;

    // Scripted: load in the B1 window (cycles 12..14), expect Start only
    guard = 0;
    while (bc < 32'd12 && guard < 1000) begin tick(); guard++; end
    chk("wait_b1", bc, 32'd12);
    s_strobe = 1'b1;
    repeat (3) tick();
    s_strobe = 1'b0;
    tick();
    chk("s_latch_b1", {24'd0, s_latched}, 32'h08);
    pat = 8'h08;
    for (int i = 0; i < 8; i++) s_rd_pulse($sformatf("s_b1_bit%0d", i), pat[i]);

    // Scripted: load past T3 (cycles 33..35), expect Right only
    guard = 0;
    while (bc < 32'd33 && guard < 1000) begin tick(); guard++; end
    chk("wait_b3", bc, 32'd33);
    s_strobe = 1'b1;
    repeat (3) tick();
    s_strobe = 1'b0;
    tick();
    chk("s_latch_b3", {24'd0, s_latched}, 32'h80);
    pat = 8'h80;
    for (int i = 0; i < 8; i++) s_rd_pulse($sformatf("s_b3_bit%0d", i), pat[i]);

    // Live: 0x89 shifted out A first, then ones after the eighth read
    btns = 8'b1000_1001;
    strobe = 1'b1; tick();
    strobe = 1'b0; tick();
    chk("load_latched", {24'd0, latched}, 32'h89);
    pat = 8'h89;
    for (int i = 0; i < 8; i++) rd_pulse($sformatf("bit%0d", i), pat[i]);
    chk("count8", {28'd0, read_count}, 32'd8);
    for (int i = 0; i < 3; i++) rd_pulse($sformatf("extra%0d", i), 1'b1);
    chk("count_sat", {28'd0, read_count}, 32'd8);
    chk("latched_ff", {24'd0, latched}, 32'hFF);

    // Strobe held: data tracks btns[0] one clock later, rd ignored
    strobe = 1'b1; btns = 8'h01; tick();
    chk("strb_d1", {31'd0, data}, 32'd1);
    btns = 8'h00; rd = 1'b1;
    chk("strb_lag", {31'd0, data}, 32'd1);
    tick();
    chk("strb_d0", {31'd0, data}, 32'd0);
    rd = 1'b0; tick();
    chk("strb_rdfall", {31'd0, data}, 32'd0);
    chk("strb_count", {28'd0, read_count}, 32'd0);
    btns = 8'h01; tick();
    chk("strb_d1b", {31'd0, data}, 32'd1);
    strobe = 1'b0;

    // rd held high for 10 cycles counts as a single read
    btns = 8'h89;
    strobe = 1'b1; tick();
    strobe = 1'b0; tick();
    rd = 1'b1;
    repeat (10) tick();
    chk("hold_data", {31'd0, data}, 32'd1);
    chk("hold_count", {28'd0, read_count}, 32'd0);
    rd = 1'b0; tick();
    chk("hold_count1", {28'd0, read_count}, 32'd1);
    chk("hold_latched", {24'd0, latched}, 32'hC4);

    // Strobe coincident with rd falling edge: reload wins
    rd = 1'b1; tick();
    rd = 1'b0; strobe = 1'b1; btns = 8'h02; tick();
    strobe = 1'b0; tick();
    chk("coinc_latched", {24'd0, latched}, 32'h02);
    chk("coinc_count", {28'd0, read_count}, 32'd0);
    chk("coinc_data", {31'd0, data}, 32'd0);

    // Reset mid-sequence drops state; next read without strobe returns 0
    btns = 8'hFF;
    strobe = 1'b1; tick();
    strobe = 1'b0; tick();
    rst = 1'b0; tick();
    rst = 1'b1; tick();
    rd_pulse("post_rst_read", 1'b0);
    chk("post_rst_count", {28'd0, read_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
